// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard/stall control
// Contents:
//   state_t    - control FSM states (BOOT, RUN, LU_STALL, MEM_WAIT)
//   NOP_INSTR  - encoding loaded into IF/ID on a flush (addi x0, x0, 0)
//   REG_X0     - index of the hard-wired zero register
package hazard_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        LU_STALL = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator
// Ports:
//   mem_read        in  1  instruction in EX is a load
//   rd              in  5  destination register of the EX instruction
//   rs1, rs2        in  5  source registers of the ID instruction
//   use_rs1/use_rs2 in  1  ID instruction actually reads rs1/rs2
//   hazard          out 1  ID must wait one cycle for the load result
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);

    // Writes to x0 are discarded, so a load to x0 never creates a dependency.
    assign hazard = mem_read && (rd != REG_X0) &&
                    ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: enable/flush sequencing for the PC, IF/ID, ID/EX and EX/MEM registers
// Optional feature macro: HAZARD_PERF_EN (stall/flush cycle counters)
// Ports:
//   clk, reset                 in  1     clock, asynchronous active-high reset
//   id_rs1, id_rs2             in  5     ID source registers
//   id_use_rs1, id_use_rs2     in  1     ID instruction reads rs1/rs2
//   ex_mem_read, ex_rd         in  1/5   EX load flag and destination
//   ex_branch_taken            in  1     EX branch/jump resolved taken
//   imem_ready                 in  1     instruction fetch data valid
//   dmem_req, dmem_ready       in  1     MEM access issued / completed
//   pc_en, ifid_en             out 1     PC and IF/ID write enables
//   ifid_flush, idex_flush     out 1     IF/ID NOP load, ID/EX bubble load
//   exmem_en                   out 1     EX/MEM and MEM/WB write enable
//   stall_cycles, flush_cycles out CNT_W perf counters (HAZARD_PERF_EN only)
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);

    state_t state, state_next;
    logic   hazard;
    logic   boot, freeze, run, br, lu, ifw;

    load_use_detect u_lud (
        .mem_read (ex_mem_read),
        .rd       (ex_rd),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .use_rs1  (id_use_rs1),
        .use_rs2  (id_use_rs2),
        .hazard   (hazard)
    );

    // Priority decode. In MEM_WAIT the freeze holds purely on dmem_ready; the
    // release cycle falls through to the normal RUN rules. The load-use term is
    // masked in LU_STALL because the dependent instruction already waited once.
    always_comb begin
        boot   = reset || (state == BOOT);
        freeze = !boot && ((state == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready));
        run    = !boot && !freeze;
        br     = run && ex_branch_taken;
        lu     = run && !ex_branch_taken && hazard && (state != LU_STALL);
        ifw    = run && !ex_branch_taken && !lu && !imem_ready;
        pc_en      = run && !lu && !ifw;
        ifid_en    = run && !lu;
        ifid_flush = boot || br || ifw;
        idex_flush = boot || br || lu;
        exmem_en   = !reset && !freeze;
        state_next = freeze ? MEM_WAIT : lu ? LU_STALL : RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_next;
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // BOOT is excluded: its forced stall/flush is reset sequencing, not a hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else if (state != BOOT) begin
            if (!pc_en && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (idex_flush && flush_cycles != CNT_MAX)
                flush_cycles <= flush_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed table-driven bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic       imem_ready, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_en;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
`endif
    );

    // exp packs {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       bt, ir, dq, dr;
        logic [4:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_mem_read = v.mr; ex_rd = v.rd; ex_branch_taken = v.bt;
        imem_ready = v.ir; dmem_req = v.dq; dmem_ready = v.dr;
    endtask

    task automatic idle();
        drive('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
    endtask

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {pc,ifid_en,ifid_fl,idex_fl,exmem}=%b required %b", name, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rs1    rs2    u1 u2 mr rd     bt ir dq dr exp
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b00111}); // 0 BOOT
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b11001}); // 1 RUN
        vq.push_back('{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0, 0, 5'b00011}); // 2 load-use rs1
        vq.push_back('{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0, 0, 5'b11001}); // 3 LU_STALL masked
        vq.push_back('{5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 1, 0, 0, 5'b11001}); // 4 rd=x0
        vq.push_back('{5'd5, 5'd7, 0, 1, 1, 5'd7, 0, 1, 0, 0, 5'b00011}); // 5 load-use rs2
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b11001}); // 6 LU_STALL idle
        vq.push_back('{5'd9, 5'd0, 0, 0, 1, 5'd9, 0, 1, 0, 0, 5'b11001}); // 7 rs1 not used
        vq.push_back('{5'd9, 5'd0, 1, 0, 0, 5'd9, 0, 1, 0, 0, 5'b11001}); // 8 not a load
        vq.push_back('{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0, 0, 5'b11111}); // 9 branch beats hazard
        vq.push_back('{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0, 0, 5'b00011}); // 10 still RUN
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 5'b01101}); // 11 LU_STALL imem wait
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 5'b01101}); // 12 imem wait
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 5'b11111}); // 13 branch beats imem
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, 0, 5'b00000}); // 14 mem beats branch
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, 0, 5'b00000}); // 15 MEM_WAIT
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, 1, 5'b11111}); // 16 release + branch
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b11001}); // 17 RUN
        vq.push_back('{5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 1, 0, 0, 5'b00011}); // 18 load-use
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, 5'b00000}); // 19 LU_STALL mem wait
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 5'b11001}); // 20 release
        vq.push_back('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b11001}); // 21 RUN

        idle();
        #3;
        chk("reset_outputs", 5'b00110);
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            chk($sformatf("vec%0d", i), vq[i].exp);
            cyc();
        end

        // Three wait cycles freeze exactly three cycles.
        for (int i = 0; i < 3; i++) begin
            idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
            #1;
            chk($sformatf("memwait%0d", i), 5'b00000);
            cyc();
        end
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("memwait_release", 5'b11001);
        cyc();

        // Reset asserted during the second wait cycle.
        idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("rst_wait1", 5'b00000);
        cyc();
        #1;
        chk("rst_wait2", 5'b00000);
        reset = 1'b1;
        #1;
        chk("rst_async", 5'b00110);
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_boot", 5'b00111);
        cyc();
        idle();
        #1;
        chk("rst_run", 5'b11001);
        cyc();

`ifdef HAZARD_PERF_EN
        reset = 1'b1;
        #1;
        chk_val("stall_reset", stall_cycles, 32'd0);
        chk_val("flush_reset", flush_cycles, 32'd0);
        cyc();
        reset = 1'b0;
        idle();
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive('{5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
            cyc();
            idle();
            cyc();
        end
        ex_branch_taken = 1'b1;
        cyc();
        idle();
        cyc();
        chk_val("stall_cycles", stall_cycles, 32'd2);
        chk_val("flush_cycles", flush_cycles, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
